// File: rtl/circle_stop_pkg.sv
// circle_stop_counter shared types: hold state machine
// encoding and wrap/stop mode constants.
package circle_stop_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD_HI = 2'd1,
    HOLD_LO = 2'd2
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_STOP = 1'b1;

endpackage

// File: rtl/circle_stop_counter.sv
// Up/down modulo counter with per-cycle wrap or stop mode,
// synchronous clamped load and overflow/underflow flags.
module circle_stop_counter
  import circle_stop_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAXVAL = (1 << WIDTH) - 1
) (
  input  logic             iClk,
  input  logic             _iRst,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             _iWrapstop,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iCount,
  input  logic             iClrFlag,
  output logic [WIDTH-1:0] oCount,
  output logic             oOverflow,
  output logic             oUnderflow,
  output logic             oHold,
  output logic             oSticky
);

  if (WIDTH < 2) begin : gBadWidth
    $error("WIDTH must be at least 2");
  end

  if (MAXVAL < 1 ||
      longint'(MAXVAL) > (longint'(1) << WIDTH) - 1)
  begin : gBadMax
    $error("MAXVAL out of range 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAXVAL);

  state_t           state, nState;
  logic [WIDTH-1:0] count, nCount;
  logic             ovf, nOvf;
  logic             unf, nUnf;
  logic             sticky, nSticky;
  logic             stopMode;

  assign stopMode = (_iWrapstop == MODE_STOP);

  always_comb begin
    nState = state;
    nCount = count;
    nOvf   = 1'b0;
    nUnf   = 1'b0;
    if (iLoad) begin
      nCount = (iCount > MAXV) ? MAXV : iCount;
      nState = RUN;
    end else if (iEn) begin
      if (iUp) begin
        if (count == MAXV) begin
          nOvf = 1'b1;
          if (stopMode) begin
            nState = HOLD_HI;
          end else begin
            nCount = '0;
            nState = RUN;
          end
        end else begin
          nCount = count + 1'b1;
          nState = RUN;
        end
      end else begin
        if (count == '0) begin
          nUnf = 1'b1;
          if (stopMode) begin
            nState = HOLD_LO;
          end else begin
            nCount = MAXV;
            nState = RUN;
          end
        end else begin
          nCount = count - 1'b1;
          nState = RUN;
        end
      end
    end
    // a new pulse beats a simultaneous clear
    if (nOvf || nUnf) begin
      nSticky = 1'b1;
    end else if (iClrFlag) begin
      nSticky = 1'b0;
    end else begin
      nSticky = sticky;
    end
  end

  always_ff @(posedge iClk or negedge _iRst) begin
    if (!_iRst) begin
      state  <= RUN;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      sticky <= 1'b0;
    end else begin
      state  <= nState;
      count  <= nCount;
      ovf    <= nOvf;
      unf    <= nUnf;
      sticky <= nSticky;
    end
  end

  assign oCount     = count;
  assign oOverflow  = ovf;
  assign oUnderflow = unf;
  assign oHold      = (state != RUN);
  assign oSticky    = sticky;

endmodule

// File: tb/tb_circle_stop_counter.sv
// Bench for circle_stop_counter (WIDTH=4, MAXVAL=9):
// directed scenarios plus random traffic against a model.
module tb_circle_stop_counter;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         iClk = 1'b0;
  logic         _iRst = 1'b0;
  logic         iEn = 1'b0;
  logic         iUp = 1'b0;
  logic         _iWrapstop = 1'b0;
  logic         iLoad = 1'b0;
  logic [W-1:0] iCount = '0;
  logic         iClrFlag = 1'b0;
  logic [W-1:0] oCount;
  logic         oOverflow, oUnderflow, oHold, oSticky;

  int checks = 0;
  int errors = 0;

  int mCount;
  bit mOvf, mUnf, mHold, mSticky;

  circle_stop_counter #(.WIDTH(W), .MAXVAL(MAX)) dut (
    .iClk(iClk), ._iRst(_iRst), .iEn(iEn), .iUp(iUp),
    ._iWrapstop(_iWrapstop), .iLoad(iLoad), .iCount(iCount),
    .iClrFlag(iClrFlag), .oCount(oCount),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow),
    .oHold(oHold), .oSticky(oSticky)
  );

  always #5 iClk = ~iClk;

  function automatic void modelReset();
    mCount = 0; mOvf = 0; mUnf = 0; mHold = 0; mSticky = 0;
  endfunction

  function automatic void modelStep(bit en, bit up, bit stop,
                                    bit ld, int val, bit clr);
    mOvf = 0;
    mUnf = 0;
    if (ld) begin
      mCount = (val > MAX) ? MAX : val;
      mHold  = 0;
    end else if (en && up) begin
      if (mCount == MAX) begin
        mOvf = 1;
        if (stop) mHold = 1;
        else begin mCount = 0; mHold = 0; end
      end else begin
        mCount++; mHold = 0;
      end
    end else if (en) begin
      if (mCount == 0) begin
        mUnf = 1;
        if (stop) mHold = 1;
        else begin mCount = MAX; mHold = 0; end
      end else begin
        mCount--; mHold = 0;
      end
    end
    if (mOvf || mUnf) mSticky = 1;
    else if (clr) mSticky = 0;
  endfunction

  task automatic step(bit en, bit up, bit stop,
                      bit ld, int val, bit clr);
    iEn = en; iUp = up; _iWrapstop = stop;
    iLoad = ld; iCount = W'(val); iClrFlag = clr;
    @(posedge iClk);
    modelStep(en, up, stop, ld, val, clr);
    #1;
  endtask

  task automatic test_reset();
    _iRst = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({oCount, oOverflow, oUnderflow, oHold, oSticky} !== 8'h0) begin
      errors++;
      $display("FAIL reset: got cnt=%0d ovf=%b unf=%b hold=%b stk=%b want all 0",
               oCount, oOverflow, oUnderflow, oHold, oSticky);
    end
    @(negedge iClk);
    _iRst = 1'b1;
  endtask

  task automatic test_wrap_up();
    for (int k = 1; k <= 12; k++) begin
      step(1, 1, 0, 0, 0, 0);
      checks++;
      if (oCount !== W'(k % 10) || oOverflow !== (k == 10)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got cnt=%0d ovf=%b want cnt=%0d ovf=%b",
                 k, oCount, oOverflow, k % 10, k == 10);
      end
    end
    checks++;
    if (oSticky !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky: got %b want 1", oSticky);
    end
  endtask

  task automatic test_stop_top();
    step(0, 0, 1, 1, 8, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 1, 0, 0, 0);
      checks++;
      if (oCount !== 4'd9 || oOverflow !== (k >= 2) ||
          oHold !== (k >= 2)) begin
        errors++;
        $display("FAIL stop_top[%0d]: got cnt=%0d ovf=%b hold=%b want 9 %b %b",
                 k, oCount, oOverflow, oHold, k >= 2, k >= 2);
      end
    end
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if (oCount !== 4'd8 || oHold !== 1'b0 || oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL stop_release: got cnt=%0d hold=%b ovf=%b want 8 0 0",
               oCount, oHold, oOverflow);
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if (oCount !== 4'd0 || oUnderflow !== 1'b1 || oHold !== 1'b1) begin
      errors++;
      $display("FAIL under_stop: got cnt=%0d unf=%b hold=%b want 0 1 1",
               oCount, oUnderflow, oHold);
    end
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (oCount !== 4'd9 || oUnderflow !== 1'b1 || oHold !== 1'b0) begin
      errors++;
      $display("FAIL under_wrap: got cnt=%0d unf=%b hold=%b want 9 1 0",
               oCount, oUnderflow, oHold);
    end
  endtask

  task automatic test_load_clamp();
    step(1, 1, 1, 1, 15, 0);
    checks++;
    if (oCount !== 4'd9 || oOverflow !== 1'b0 ||
        oUnderflow !== 1'b0 || oHold !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: got cnt=%0d ovf=%b unf=%b hold=%b want 9 0 0 0",
               oCount, oOverflow, oUnderflow, oHold);
    end
  endtask

  task automatic test_sticky_race();
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (oSticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_pre: got %b want 0", oSticky);
    end
    step(1, 1, 0, 0, 0, 1);
    checks++;
    if (oSticky !== 1'b1 || oOverflow !== 1'b1 || oCount !== 4'd0) begin
      errors++;
      $display("FAIL sticky_race: got stk=%b ovf=%b cnt=%0d want 1 1 0",
               oSticky, oOverflow, oCount);
    end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (oSticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b want 0", oSticky);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 1, 9, 0);
    step(1, 1, 1, 0, 0, 0);
    checks++;
    if (oHold !== 1'b1 || oCount !== 4'd9) begin
      errors++;
      $display("FAIL hold_entry: got hold=%b cnt=%0d want 1 9",
               oHold, oCount);
    end
    iEn = 1'b0;
    @(negedge iClk);
    #1 _iRst = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({oCount, oOverflow, oUnderflow, oHold, oSticky} !== 8'h0) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d ovf=%b unf=%b hold=%b stk=%b want all 0",
               oCount, oOverflow, oUnderflow, oHold, oSticky);
    end
    @(negedge iClk);
    _iRst = 1'b1;
    step(1, 1, 1, 0, 0, 0);
    checks++;
    if (oCount !== 4'd1 || oHold !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_step: got cnt=%0d hold=%b want 1 0",
               oCount, oHold);
    end
  endtask

  task automatic test_random();
    bit en, up, stop, ld, clr;
    int val;
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) < 8);
      up   = ($urandom_range(0, 9) < 6);
      stop = $urandom_range(0, 1);
      ld   = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 7) == 0);
      val  = $urandom_range(0, 15);
      step(en, up, stop, ld, val, clr);
      checks++;
      if (oCount !== W'(mCount) || oOverflow !== mOvf ||
          oUnderflow !== mUnf || oHold !== mHold ||
          oSticky !== mSticky) begin
        errors++;
        $display("FAIL random[%0d]: got %0d %b %b %b %b want %0d %b %b %b %b",
                 i, oCount, oOverflow, oUnderflow, oHold, oSticky,
                 mCount, mOvf, mUnf, mHold, mSticky);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_stop_top();
    test_underflow();
    test_load_clamp();
    test_sticky_race();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
